// File: rtl/hack_reg_stage.sv
// Hack CPU register stage: instruction latch, A/D registers, program counter and
// data-memory write handshake. The ALU itself sits outside and feeds alu_out/zr/ng
// back from instr_q, d_out and A/M.
module hack_reg_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] instr_in,
   input  logic        instr_valid,
   input  logic [15:0] alu_out,
   input  logic        alu_zr,
   input  logic        alu_ng,
   input  logic        mem_ready,
   output logic        fetch_req,
   output logic [15:0] instr_q,
   output logic [15:0] a_out,
   output logic [15:0] d_out,
   output logic [15:0] pc,
   output logic        write_m,
   output logic [15:0] out_m,
   output logic [14:0] address_m
);

   typedef enum logic [1:0] {StFetch, StExec, StMwait} state_e;

   state_e      state;
   logic        is_c;
   logic        dest_a;
   logic        dest_d;
   logic        dest_m;
   logic        jump;
   logic        mem_op;
   logic        exec_phase;
   logic        commit;
   logic        load_a;
   logic        load_d;
   logic [15:0] a_sel;

   // Instruction decode and commit qualification.
   always_comb begin
      is_c       = instr_q[15];
      dest_a     = instr_q[5];
      dest_d     = instr_q[4];
      dest_m     = instr_q[3];
      jump       = is_c & ((instr_q[2] & alu_ng) |
                           (instr_q[1] & alu_zr) |
                           (instr_q[0] & ~alu_ng & ~alu_zr));
      mem_op     = is_c & dest_m;
      exec_phase = (state == StExec) || (state == StMwait);
      // A memory write may only retire once the memory has taken it.
      commit     = exec_phase & (~mem_op | mem_ready);
      load_a     = ~is_c | dest_a;
      load_d     = is_c & dest_d;
      a_sel      = is_c ? alu_out : instr_q;
   end

   // Handshake outputs; fetch_req is masked by reset so it reads 0 while held.
   always_comb begin
      fetch_req = (state == StFetch) & ~reset;
      write_m   = exec_phase & mem_op;
      out_m     = alu_out;
      address_m = a_out[14:0];
   end

   // Sequencer plus architectural state; nothing changes unless commit is true.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= StFetch;
         instr_q <= 16'h0000;
         a_out   <= 16'h0000;
         d_out   <= 16'h0000;
         pc      <= 16'h0000;
      end else begin
         case (state)
            StFetch: begin
               if (instr_valid) begin
                  instr_q <= instr_in;
                  state   <= StExec;
               end
            end
            StExec, StMwait: begin
               if (commit) begin
                  if (load_a) a_out <= a_sel;
                  if (load_d) d_out <= alu_out;
                  // Jump target is A as it stood before this commit.
                  pc    <= jump ? a_out : pc + 16'd1;
                  state <= StFetch;
               end else begin
                  state <= StMwait;
               end
            end
            default: state <= StFetch;
         endcase
      end
   end

endmodule

// File: tb/tb_hack_reg_stage.sv
// Scoreboard bench for hack_reg_stage: a driver issues instructions and pushes
// the architecturally expected outcome; a monitor checks write cycles and the
// retired state each time the DUT returns to fetch.
module tb_hack_reg_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] instr_in = 16'h0000;
   logic        instr_valid = 1'b0;
   logic [15:0] alu_out = 16'h0000;
   logic        alu_zr = 1'b1;
   logic        alu_ng = 1'b0;
   logic        mem_ready = 1'b0;
   logic        fetch_req;
   logic [15:0] instr_q;
   logic [15:0] a_out;
   logic [15:0] d_out;
   logic [15:0] pc;
   logic        write_m;
   logic [15:0] out_m;
   logic [14:0] address_m;

   hack_reg_stage dut (
      .clock      (clock),
      .reset      (reset),
      .instr_in   (instr_in),
      .instr_valid(instr_valid),
      .alu_out    (alu_out),
      .alu_zr     (alu_zr),
      .alu_ng     (alu_ng),
      .mem_ready  (mem_ready),
      .fetch_req  (fetch_req),
      .instr_q    (instr_q),
      .a_out      (a_out),
      .d_out      (d_out),
      .pc         (pc),
      .write_m    (write_m),
      .out_m      (out_m),
      .address_m  (address_m)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pre_a;
      logic [15:0] pre_d;
      logic [15:0] pre_pc;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] pc;
      logic [15:0] out;
      int          wcyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          errors = 0;
   int          nchecks = 0;
   int          wcount = 0;
   int          stray = 0;
   bit          mon_en = 1'b0;
   bit          prev_fetch = 1'b1;

   // Architectural model state
   logic [15:0] ma = 16'h0000;
   logic [15:0] md = 16'h0000;
   logic [15:0] mpc = 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_alu(input logic [15:0] v);
      alu_out = v;
      alu_zr  = (v == 16'h0000);
      alu_ng  = v[15];
   endtask

   // Issue one instruction; waits = mem_ready-low cycles before the accepting one.
   task automatic issue(input logic [15:0] w, input logic [15:0] v, input int waits);
      exp_t e;
      bit   is_c;
      bit   mem;
      bit   jmp;
      check("fetch_req_at_issue", {31'd0, fetch_req}, 32'd1);
      is_c = w[15];
      mem  = is_c && w[3];
      jmp  = is_c && ((w[2] && $signed(v) < 0) || (w[1] && v == 16'h0000) ||
                      (w[0] && $signed(v) > 0));
      e.instr  = w;
      e.pre_a  = ma;
      e.pre_d  = md;
      e.pre_pc = mpc;
      e.out    = v;
      e.pc     = jmp ? ma : mpc + 16'd1;
      if (!is_c) ma = w;
      else if (w[5]) ma = v;
      if (is_c && w[4]) md = v;
      mpc    = e.pc;
      e.a    = ma;
      e.d    = md;
      e.wcyc = mem ? waits + 1 : 0;
      sb.push_back(e);
      instr_in    = w;
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      instr_in    = 16'($urandom);
      set_alu(v);
      if (mem) begin
         for (int k = 0; k <= waits; k++) begin
            mem_ready = (k == waits);
            @(posedge clock); #1;
         end
      end else begin
         mem_ready = 1'($urandom);
         @(posedge clock); #1;
      end
      mem_ready = 1'b0;
      set_alu(16'($urandom));
      check("back_to_fetch", {31'd0, fetch_req}, 32'd1);
   endtask

   // Monitor: write-phase checks each cycle, retired state on every return to fetch.
   always @(negedge clock) begin
      if (mon_en) begin
         if (write_m) begin
            if (fetch_req) stray++;
            if (sb.size() == 0) begin
               nchecks++;
               errors++;
               $display("FAIL unexpected_write: got write_m=1 expected no pending instr");
            end else begin
               wcount++;
               check("address_m", {17'd0, address_m}, {17'd0, sb[0].pre_a[14:0]});
               check("out_m", {16'd0, out_m}, {16'd0, sb[0].out});
               check("a_frozen", {16'd0, a_out}, {16'd0, sb[0].pre_a});
               check("d_frozen", {16'd0, d_out}, {16'd0, sb[0].pre_d});
               check("pc_frozen", {16'd0, pc}, {16'd0, sb[0].pre_pc});
               check("instr_frozen", {16'd0, instr_q}, {16'd0, sb[0].instr});
            end
         end
         if (fetch_req && !prev_fetch) begin
            if (sb.size() == 0) begin
               nchecks++;
               errors++;
               $display("FAIL unexpected_retire: got retire expected none");
            end else begin
               mon_e = sb.pop_front();
               check("instr_q", {16'd0, instr_q}, {16'd0, mon_e.instr});
               check("a_out", {16'd0, a_out}, {16'd0, mon_e.a});
               check("d_out", {16'd0, d_out}, {16'd0, mon_e.d});
               check("pc", {16'd0, pc}, {16'd0, mon_e.pc});
               check("write_cycles", wcount, mon_e.wcyc);
            end
            wcount = 0;
         end
         prev_fetch = fetch_req;
      end
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
      check("rst_write_m", {31'd0, write_m}, 32'd0);
      check("rst_a", {16'd0, a_out}, 32'd0);
      check("rst_d", {16'd0, d_out}, 32'd0);
      check("rst_pc", {16'd0, pc}, 32'd0);
      check("rst_instr", {16'd0, instr_q}, 32'd0);
      reset = 1'b0;
      #1;
      check("fetch_after_rst", {31'd0, fetch_req}, 32'd1);
      prev_fetch = 1'b1;
      mon_en     = 1'b1;

      // Directed cases
      issue(16'h0005, 16'h1234, 0);          // @5
      issue(16'hEC10, 16'h0005, 0);          // D=A
      issue(16'h0010, 16'h0000, 0);          // @16
      issue(16'hE308, 16'h0005, 3);          // M=D with three stalled cycles
      issue(16'h0020, 16'h0000, 0);          // @32
      issue(16'hE304, 16'hFFFF, 0);          // D;JLT taken
      issue(16'h0020, 16'h0000, 0);
      issue(16'hE304, 16'h0003, 0);          // D;JLT not taken
      issue(16'hEEA0, 16'hFFFF, 0);          // A=-1
      issue(16'hEA87, 16'h0000, 0);          // 0;JMP to FFFF
      issue(16'h0001, 16'h0000, 0);          // pc wraps to 0
      issue(16'h0007, 16'h0000, 0);          // @7
      issue(16'hEEAF, 16'h0009, 0);          // AM=..;JMP, old A is target

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         int idle;
         idle = int'($urandom_range(0, 2));
         for (int k = 0; k < idle; k++) begin
            instr_in = 16'($urandom);
            @(posedge clock); #1;
         end
         issue(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      end

      repeat (2) @(posedge clock);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      check("write_in_fetch", stray, 0);
      mon_en = 1'b0;

      // Reset while waiting on memory: abort without commit
      instr_in    = 16'hE308;
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      mem_ready   = 1'b0;
      @(posedge clock); #1;
      check("mwait_write_m", {31'd0, write_m}, 32'd1);
      check("mwait_fetch_req", {31'd0, fetch_req}, 32'd0);
      #2 reset = 1'b1;
      #1;
      check("abort_write_m", {31'd0, write_m}, 32'd0);
      check("abort_fetch_req", {31'd0, fetch_req}, 32'd0);
      check("abort_a", {16'd0, a_out}, 32'd0);
      check("abort_d", {16'd0, d_out}, 32'd0);
      check("abort_pc", {16'd0, pc}, 32'd0);
      check("abort_instr", {16'd0, instr_q}, 32'd0);
      @(posedge clock); #1;
      reset     = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("refetch_after_abort", {31'd0, fetch_req}, 32'd1);
      @(posedge clock); #1;
      check("no_write_after_abort", {31'd0, write_m}, 32'd0);
      check("pc_after_abort", {16'd0, pc}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, nchecks);
      $finish;
   end

endmodule

// File: doc/hack_reg_stage.md
HACK_REG_STAGE -- requirements
Module: hack_reg_stage

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port clock, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port instr_in, input, 16, instruction word from program memory.
REQ-005 SHALL have port instr_valid, input, 1, instr_in valid this cycle.
REQ-006 SHALL have port alu_out, input, 16, external combinational ALU result computed from instr_q, d_out and A/M.
REQ-007 SHALL have port alu_zr, input, 1, alu_out == 0.
REQ-008 SHALL have port alu_ng, input, 1, alu_out < 0 (two's complement).
REQ-009 SHALL have port mem_ready, input, 1, data memory accepts the write this cycle.
REQ-010 SHALL have port fetch_req, output, 1, requests the instruction at pc.
REQ-011 SHALL have port instr_q, output, 16, latched current instruction.
REQ-012 SHALL have port a_out, output, 16, A register.
REQ-013 SHALL have port d_out, output, 16, D register.
REQ-014 SHALL have port pc, output, 16, program counter.
REQ-015 SHALL have port write_m, output, 1, data memory write strobe.
REQ-016 SHALL have port out_m, output, 16, write data, equal to alu_out.
REQ-017 SHALL have port address_m, output, 15, write address, equal to a_out[14:0].

Function
REQ-018 SHALL implement a 3-state FSM: FETCH, EXEC, MWAIT.
REQ-019 In FETCH, SHALL drive fetch_req=1; on instr_valid=1, SHALL latch instr_q<=instr_in and go to EXEC; otherwise SHALL hold FETCH.
REQ-020 SHALL classify instr_q[15]=0 as an A-instruction and instr_q[15]=1 as a C-instruction; dest bits d1/d2/d3 = instr_q[5]/[4]/[3]; jump bits j1/j2/j3 = instr_q[2]/[1]/[0].
REQ-021 SHALL select the A-register input with sel=instr_q[15]: instr_q when 0, alu_out when 1.
REQ-022 SHALL load A on commit if A-instruction, or if C-instruction with d1=1.
REQ-023 SHALL load D on commit only if C-instruction with d2=1; D SHALL be unchanged for A-instructions.
REQ-024 SHALL compute jump as C-instruction and ((j1 and alu_ng) or (j2 and alu_zr) or (j3 and not alu_ng and not alu_zr)).
REQ-025 On commit, SHALL set pc<=a_out as it stood before the commit when jump=1, else pc<=pc+1; wraps 16'hFFFF->16'h0000.
REQ-026 SHALL take a simultaneous A load and jump so that the jump target is the old A and the new A is the loaded value.
REQ-027 In EXEC with no memory write (A-instruction, or d3=0), SHALL commit in that cycle and go to FETCH.
REQ-028 In EXEC/MWAIT with C-instruction and d3=1, SHALL assert write_m=1 and drive out_m/address_m; SHALL commit and go to FETCH in the cycle mem_ready=1, else go to or stay in MWAIT without commit.
REQ-029 SHALL hold write_m=0 in FETCH and for instructions without d3.
REQ-030 SHALL hold instr_q, A, D and pc stable throughout MWAIT.
REQ-031 Minimum instruction latency SHALL be 2 cycles: FETCH with instr_valid, then EXEC with immediate commit.

Reset
REQ-032 While reset=1, asynchronously: state=FETCH; instr_q, a_out, d_out and pc=16'h0000; write_m=0; fetch_req=0.
REQ-033 After reset deasserts, fetch_req SHALL be 1 from the first cycle.
REQ-034 Reset during EXEC or MWAIT SHALL abort with no commit and no further write_m.

Verification
REQ-035 Reset, then instr_in=16'h0005 (@5) valid -> a_out=5, pc=1, d_out=0, write_m=0, 2 cycles total.
REQ-036 A=5, C-instruction D=A (d2=1), alu_out=5 -> d_out=5, pc+1.
REQ-037 A=16'h0010, C-instruction M=D (d3=1), mem_ready low 3 cycles -> write_m=1 for 4 cycles, address_m=16, registers frozen, commit on the ready cycle.
REQ-038 A=16'h0020, JLT (j1=1) with alu_ng=1 -> pc=16'h0020; same with alu_ng=0 -> pc+1.
REQ-039 pc=16'hFFFF, non-jump instruction -> pc=16'h0000.
REQ-040 AM=... JMP with old A=7 and alu_out=9, mem_ready=1 -> pc=7, a_out=9.
